// File: rtl/ffr_pkg.sv
// Shared definitions for fifo_frame_reader: FSM state encoding and output-buffer depth.
package ffr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } ffr_state_t;

    localparam int OBUF_DEPTH = 3;

endpackage

// File: rtl/ffr_out_buf.sv
// Three-entry registered buffer carrying {sof, eof, data} between the FIFO read port and the stream output.
module ffr_out_buf
    import ffr_pkg::*;
#(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    localparam logic [1:0] C_DEPTH    = 2'(OBUF_DEPTH);
    localparam logic [1:0] C_LAST_PTR = 2'(OBUF_DEPTH - 1);

    logic [W-1:0] r_mem [OBUF_DEPTH];
    logic [1:0]   r_wr_ptr;
    logic [1:0]   r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = pop & (r_count != 2'd0);
    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign w_push = push & ((r_count != C_DEPTH) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= (r_wr_ptr == C_LAST_PTR) ? 2'd0 : r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? 2'd0 : r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == C_DEPTH);
    assign empty = (r_count == 2'd0);

endmodule

// File: rtl/fifo_frame_reader.sv
// Pulls whole FRAME_LEN-word frames out of the async FIFO read port and streams them with sof/eof markers.
// Optional macro FFR_STALL_CNT_EN adds a saturating stall_cnt output.
module fifo_frame_reader
    import ffr_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int FRAME_LEN  = 8,
    parameter int USEDW_W    = $clog2(FIFO_DEPTH)
) (
    input  logic               rd_clk,
    input  logic               rrst_n,
    input  logic               enable,
    output logic               fifo_rd_en,
    input  logic [DATA_W-1:0]  fifo_rd_data,
    input  logic               fifo_rd_empty,
    input  logic               fifo_rd_full,
    input  logic [USEDW_W-1:0] fifo_rd_usedw,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_sof,
    output logic               m_eof,
    output logic               busy,
    output logic [15:0]        frame_cnt
`ifdef FFR_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int ISS_W = $clog2(FRAME_LEN + 1);
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [ISS_W-1:0]   C_FRAME_LEN   = ISS_W'(FRAME_LEN);
    localparam logic [ISS_W-1:0]   C_LAST_ISSUE  = ISS_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]   C_LAST_IDX    = IDX_W'(FRAME_LEN - 1);
    localparam logic [USEDW_W:0]   C_FRAME_USEDW = (USEDW_W + 1)'(FRAME_LEN);

    ffr_state_t         r_state;
    logic [ISS_W-1:0]   r_issued;
    logic               r_inflight;
    logic [IDX_W-1:0]   r_wr_idx;
    logic [15:0]        r_frame_cnt;

    logic               w_frame_ok;
    logic               w_room;
    logic               w_rd_en;
    logic               w_handshake;
    logic               w_eof_shake;
    logic [1:0]         w_buf_cnt;
    logic               w_buf_full;
    logic               w_buf_empty;
    logic [DATA_W+1:0]  w_push_word;
    logic [DATA_W+1:0]  w_head;

    // usedw wraps to 0 at full, so the full flag alone must also qualify a frame.
    assign w_frame_ok = fifo_rd_full | ({1'b0, fifo_rd_usedw} >= C_FRAME_USEDW);

    // Room exists while buffered words plus the word in flight stay below three.
    assign w_room  = ~w_buf_full & ~((w_buf_cnt == 2'd2) & r_inflight);
    assign w_rd_en = (r_state == BURST) & (r_issued < C_FRAME_LEN) & ~fifo_rd_empty & w_room;
    assign fifo_rd_en = w_rd_en;

    assign m_valid                = ~w_buf_empty;
    assign {m_sof, m_eof, m_data} = w_head;
    assign w_handshake            = m_valid & m_ready;
    assign w_eof_shake            = w_handshake & m_eof;
    assign busy                   = (r_state != IDLE);
    assign frame_cnt              = r_frame_cnt;

    assign w_push_word = {(r_wr_idx == '0), (r_wr_idx == C_LAST_IDX), fifo_rd_data};

    always_ff @(posedge rd_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state  <= IDLE;
            r_issued <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable && w_frame_ok) begin
                        r_state  <= BURST;
                        r_issued <= '0;
                    end
                end
                BURST: begin
                    if (w_rd_en) begin
                        r_issued <= r_issued + 1'b1;
                        if (r_issued == C_LAST_ISSUE) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_eof_shake) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Marks are attached as words enter the buffer; frames never overlap inside it.
    always_ff @(posedge rd_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_inflight  <= 1'b0;
            r_wr_idx    <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_inflight <= w_rd_en;
            if (r_inflight) begin
                r_wr_idx <= (r_wr_idx == C_LAST_IDX) ? '0 : r_wr_idx + 1'b1;
            end
            if (w_eof_shake) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

`ifdef FFR_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge rd_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_stall_cnt <= '0;
        end else if (m_valid && !m_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    ffr_out_buf #(
        .W (DATA_W + 2)
    ) u_out_buf (
        .clk       (rd_clk),
        .rst_n     (rrst_n),
        .push      (r_inflight),
        .push_data (w_push_word),
        .pop       (w_handshake),
        .head      (w_head),
        .count     (w_buf_cnt),
        .full      (w_buf_full),
        .empty     (w_buf_empty)
    );

endmodule
